pst_if: RTL and testbench
=========================

Name: pst_if

Overview:
- Pipelined instruction-fetch stage, directly upstream of the decode stage.
- Owns the PC register and drives the word address of the combinational instruction ROM.
- Selects the next PC from sequential fetch, branch/jump redirect, or interrupt entry.
- Holds the IF/ID pipeline register that feeds decode, including the bubble/flush/stall handling and a HALT state entered on syscall halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IM_AW, 10, instruction-ROM word-address width
NOP_INST, 32'h0000_0000, instruction word inserted for bubbles

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
en  in  1  global step enable; 0 freezes every register, including state and counter
stall  in  1  hazard-unit hold: keep PC and IF/ID contents
flush  in  1  squash IF/ID (insert bubble)
redir_en  in  1  taken branch/jump from a later stage
redir_pc  in  32  redirect target
irq_en  in  1  interrupt accepted (decode-stage is_irq)
irq_pc  in  32  interrupt handler address
halt  in  1  syscall halt request
resume  in  1  leave HALT state
im_data  in  32  ROM word at im_addr, combinational, same cycle
im_addr  out  IM_AW  pc[IM_AW+1:2]
pc  out  32  current fetch PC
id_inst  out  32  IF/ID instruction
id_pc  out  32  IF/ID PC
id_pc_4  out  32  IF/ID PC+4
id_valid  out  1  IF/ID holds a real instruction
halted  out  1  state == HALT
fetch_cnt  out  32  fetched-instruction counter (see Optional Feature)

Behaviour:
- All registers update only on a rising clk edge with en=1. When en=0 (and rst_n=1), nothing changes.
- Reset, rst_n=0 at an edge, overrides en and everything else:
  - pc=RESET_PC
  - id_inst=NOP_INST, id_pc=0, id_pc_4=0, id_valid=0
  - state=RUN, fetch_cnt=0
- Target alignment: redir_pc and irq_pc have bits [1:0] forced to 0 before loading.
- pc+4 wraps modulo 2^32; 32'hFFFF_FFFC+4 gives 0.
- im_addr is purely combinational from pc. Fetch latency is 1 cycle: the word at pc appears in id_inst after the next enabled edge.
- State RUN, next-PC priority, highest first:
  1. irq_en: pc<=irq_pc; IF/ID<=bubble.
  2. redir_en: pc<=redir_pc; IF/ID<=bubble. Redirect wins over stall.
  3. halt: pc held; IF/ID<=bubble; state<=HALT.
  4. stall: pc held. IF/ID is held, unless flush=1, in which case IF/ID<=bubble.
  5. Otherwise: pc<=pc+4. IF/ID<={im_data, pc, pc+4, valid=1}, unless flush=1, in which case IF/ID<=bubble and pc still advances.
- State HALT:
  - pc held; IF/ID kept as bubble.
  - irq_en: pc<=irq_pc; state<=RUN.
  - Else resume: state<=RUN; fetch restarts at the held pc on the following edge.
  - redir_en, stall and flush are ignored.
- Bubble definition: id_inst=NOP_INST, id_pc=0, id_pc_4=0, id_valid=0.
- halted = (state==HALT), registered.

Optional Feature:
- Macro: IF_FETCH_CNT_EN.
- Defined:
  - fetch_cnt is a 32-bit counter, incremented on each enabled edge where IF/ID loads a valid instruction (rule 5 with flush=0).
  - It wraps at 2^32 and is cleared by reset.
- Undefined:
  - No counter register is built; fetch_cnt is tied to 32'h0.

Test Plan:
1. Reset with RESET_PC=0, then 3 enabled cycles with ROM words A,B,C at words 0,1,2. Required: id_inst A,B,C on cycles 1-3; id_pc 0,4,8; id_pc_4 4,8,12; fetch_cnt=3 (with IF_FETCH_CNT_EN).
2. At pc=8, assert stall for 2 cycles, then flush together with stall. Required: pc stays 8 and id_inst is held for 2 cycles; the flush cycle gives id_valid=0, id_inst=NOP_INST, pc still 8.
3. redir_en=1, redir_pc=32'h0000_0103, with stall=1 in the same cycle. Required: pc=32'h100; IF/ID bubble; next cycle id_pc=32'h100.
4. irq_en, redir_en and halt all asserted together, irq_pc=32'h4000. Required: pc=32'h4000, state stays RUN, bubble.
5. halt at pc=32'h20; 3 idle cycles; then resume. Required: halted=1 and id_valid=0 during the idle cycles, pc=32'h20 throughout; after resume, halted=0 and the next edge fetches 32'h20. Repeat with irq_en instead of resume: pc=irq_pc and halted=0.
6. Start a sequential run, drop en to 0 for 2 cycles, assert rst_n=0 with en=0. Required: registers frozen while en=0; the reset edge still loads pc=RESET_PC, id_valid=0, fetch_cnt=0. Separately, start at pc=32'hFFFF_FFFC: next pc=0.

Source files
------------

// File: rtl/pst_if.sv
// ============================================================================
// pst_if -- pipelined instruction-fetch stage
//
// Owns the fetch PC, addresses a combinational instruction ROM and holds the
// IF/ID pipeline register feeding decode. The next PC comes from sequential
// fetch, a redirect from a later stage, or interrupt entry. A HALT state is
// entered on a syscall halt and left on resume or on an interrupt.
//
// Parameters:
//   RESET_PC  PC value loaded on reset
//   IM_AW     instruction-ROM word-address width
//   NOP_INST  instruction word used for bubbles
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset, sampled on rising clk
//   en         global step enable; 0 freezes every register
//   stall      hazard hold: keep PC and IF/ID contents
//   flush      squash IF/ID (insert bubble)
//   redir_en   taken branch/jump from a later stage
//   redir_pc   redirect target (bits [1:0] ignored)
//   irq_en     interrupt accepted
//   irq_pc     interrupt handler address (bits [1:0] ignored)
//   halt       syscall halt request
//   resume     leave HALT state
//   im_data    ROM word at im_addr, combinational, same cycle
//   im_addr    ROM word address, pc[IM_AW+1:2]
//   pc         current fetch PC
//   id_inst    IF/ID instruction
//   id_pc      IF/ID PC
//   id_pc_4    IF/ID PC+4
//   id_valid   IF/ID holds a real instruction
//   halted     registered HALT state flag
//   fetch_cnt  fetched-instruction counter
//
// Build option:
//   IF_FETCH_CNT_EN  when defined, fetch_cnt counts every enabled edge that
//                    loads a valid instruction into IF/ID; when undefined no
//                    counter is built and fetch_cnt reads as zero.
// ============================================================================
module pst_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_AW    = 10,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             stall,
    input  logic             flush,
    input  logic             redir_en,
    input  logic [31:0]      redir_pc,
    input  logic             irq_en,
    input  logic [31:0]      irq_pc,
    input  logic             halt,
    input  logic             resume,
    input  logic [31:0]      im_data,
    output logic [IM_AW-1:0] im_addr,
    output logic [31:0]      pc,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_pc_4,
    output logic             id_valid,
    output logic             halted,
    output logic [31:0]      fetch_cnt
);

    // Fetch state
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    // What the IF/ID register does on an enabled edge
    localparam logic [1:0] ID_HOLD   = 2'd0;
    localparam logic [1:0] ID_LOAD   = 2'd1;
    localparam logic [1:0] ID_BUBBLE = 2'd2;

    logic [0:0]  state;
    logic [0:0]  state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] pc_plus4;
    logic [31:0] redir_al;
    logic [31:0] irq_al;
    logic [1:0]  id_op;

    // Targets are word aligned; masking keeps every input bit in use.
    assign redir_al = redir_pc & 32'hFFFF_FFFC;
    assign irq_al   = irq_pc   & 32'hFFFF_FFFC;

    // Wraps naturally modulo 2^32.
    assign pc_plus4 = pc + 32'd4;

    assign im_addr  = pc[IM_AW+1:2];
    assign halted   = (state == ST_HALT);

    // ------------------------------------------------------------------------
    // Next-state / next-PC selection
    // ------------------------------------------------------------------------
    // NOTE: every output of this block is given a default before the case so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pc_nxt    = pc;
        state_nxt = state;
        id_op     = ID_HOLD;

        case (state)
            ST_RUN: begin
                if (irq_en) begin
                    pc_nxt = irq_al;
                    id_op  = ID_BUBBLE;
                end else if (redir_en) begin
                    // Redirect outranks a stall: the held instruction is on
                    // the wrong path anyway.
                    pc_nxt = redir_al;
                    id_op  = ID_BUBBLE;
                end else if (halt) begin
                    id_op     = ID_BUBBLE;
                    state_nxt = ST_HALT;
                end else if (stall) begin
                    id_op = flush ? ID_BUBBLE : ID_HOLD;
                end else begin
                    // A flush squashes the fetched word but the PC still
                    // moves on.
                    pc_nxt = pc_plus4;
                    id_op  = flush ? ID_BUBBLE : ID_LOAD;
                end
            end

            ST_HALT: begin
                // Redirect, stall and flush have no effect while halted.
                id_op = ID_BUBBLE;
                if (irq_en) begin
                    pc_nxt    = irq_al;
                    state_nxt = ST_RUN;
                end else if (resume) begin
                    // PC is held, so fetch restarts where it stopped.
                    state_nxt = ST_RUN;
                end
            end

            default: begin
                state_nxt = ST_RUN;
                id_op     = ID_BUBBLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // PC, state and IF/ID register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and checked before en, so a reset edge
        // takes effect even while the stage is frozen.
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= ST_RUN;
            id_inst  <= NOP_INST;
            id_pc    <= 32'h0;
            id_pc_4  <= 32'h0;
            id_valid <= 1'b0;
        end else if (en) begin
            pc    <= pc_nxt;
            state <= state_nxt;
            case (id_op)
                ID_LOAD: begin
                    id_inst  <= im_data;
                    id_pc    <= pc;
                    id_pc_4  <= pc_plus4;
                    id_valid <= 1'b1;
                end
                ID_BUBBLE: begin
                    id_inst  <= NOP_INST;
                    id_pc    <= 32'h0;
                    id_pc_4  <= 32'h0;
                    id_valid <= 1'b0;
                end
                default: begin
                    // ID_HOLD: keep current contents
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Fetched-instruction counter
    // ------------------------------------------------------------------------
`ifdef IF_FETCH_CNT_EN
    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= 32'h0;
        end else if (en && (id_op == ID_LOAD)) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign fetch_cnt = cnt;
`else
    assign fetch_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pst_if.sv
// ============================================================================
// tb_pst_if -- self-checking bench for pst_if
//
// A directed table of stimulus rows with hand-derived expectations for pc,
// id_pc, id_valid and halted, followed by randomized stimulus. Every cycle
// all outputs are also compared against a cycle-level behavioural model of
// the fetch stage kept in this bench.
// ============================================================================
module tb_pst_if;

    logic        clk = 1'b0;
    logic        rst_n, en, stall, flush, redir_en, irq_en, halt, resume;
    logic [31:0] redir_pc, irq_pc, im_data;
    logic [9:0]  im_addr;
    logic [31:0] pc, id_inst, id_pc, id_pc_4, fetch_cnt;
    logic        id_valid, halted;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        en;
        logic        stall;
        logic        flush;
        logic        redir_en;
        logic [31:0] redir_pc;
        logic        irq_en;
        logic [31:0] irq_pc;
        logic        halt;
        logic        resume;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] id_pc;
        logic [31:0] id_pc4;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
    } model_t;

    typedef struct packed {
        stim_t       s;
        logic [31:0] e_pc;
        logic [31:0] e_id_pc;
        logic        e_valid;
        logic        e_halted;
    } vec_t;

    // Instruction ROM contents, a fixed function of the word address.
    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return 32'hC0DE_0000 ^ {a, 22'h0} ^ {22'h0, a};
    endfunction

    assign im_data = rom_word(im_addr);

    pst_if dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .stall    (stall),
        .flush    (flush),
        .redir_en (redir_en),
        .redir_pc (redir_pc),
        .irq_en   (irq_en),
        .irq_pc   (irq_pc),
        .halt     (halt),
        .resume   (resume),
        .im_data  (im_data),
        .im_addr  (im_addr),
        .pc       (pc),
        .id_inst  (id_inst),
        .id_pc    (id_pc),
        .id_pc_4  (id_pc_4),
        .id_valid (id_valid),
        .halted   (halted),
        .fetch_cnt(fetch_cnt)
    );

    model_t m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic stim_t st(input bit r, input bit e, input bit s, input bit f,
                                 input bit re, input logic [31:0] rp,
                                 input bit ie, input logic [31:0] ip,
                                 input bit h, input bit rs);
        stim_t x;
        x = '{rst_n: r, en: e, stall: s, flush: f, redir_en: re, redir_pc: rp,
              irq_en: ie, irq_pc: ip, halt: h, resume: rs};
        return x;
    endfunction

    function automatic stim_t run();
        return st(1, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    endfunction

    function automatic model_t bubble(input model_t c);
        model_t n = c;
        n.inst   = 32'h0;
        n.id_pc  = 32'h0;
        n.id_pc4 = 32'h0;
        n.valid  = 1'b0;
        return n;
    endfunction

    // Behavioural model: one enabled edge of the fetch stage.
    function automatic model_t model_next(input model_t c, input stim_t s);
        model_t n = c;
        if (!s.rst_n) begin
            n        = bubble(c);
            n.pc     = 32'h0;
            n.halted = 1'b0;
            n.cnt    = 32'h0;
        end else if (!s.en) begin
            n = c;
        end else if (c.halted) begin
            n = bubble(c);
            if (s.irq_en) begin
                n.pc     = {s.irq_pc[31:2], 2'b00};
                n.halted = 1'b0;
            end else if (s.resume) begin
                n.halted = 1'b0;
            end
        end else if (s.irq_en) begin
            n    = bubble(c);
            n.pc = {s.irq_pc[31:2], 2'b00};
        end else if (s.redir_en) begin
            n    = bubble(c);
            n.pc = {s.redir_pc[31:2], 2'b00};
        end else if (s.halt) begin
            n        = bubble(c);
            n.halted = 1'b1;
        end else if (s.stall) begin
            if (s.flush) n = bubble(c);
        end else begin
            if (s.flush) begin
                n = bubble(c);
            end else begin
                n.inst   = rom_word(c.pc[11:2]);
                n.id_pc  = c.pc;
                n.id_pc4 = c.pc + 32'd4;
                n.valid  = 1'b1;
                n.cnt    = c.cnt + 32'd1;
            end
            n.pc = c.pc + 32'd4;
        end
        return n;
    endfunction

    task automatic compare_all(input string tag);
        logic [31:0] exp_cnt;
`ifdef IF_FETCH_CNT_EN
        exp_cnt = m.cnt;
`else
        exp_cnt = 32'h0;
`endif
        check({tag, ".pc"},        pc,               m.pc);
        check({tag, ".im_addr"},   {22'h0, im_addr}, {22'h0, m.pc[11:2]});
        check({tag, ".id_inst"},   id_inst,          m.inst);
        check({tag, ".id_pc"},     id_pc,            m.id_pc);
        check({tag, ".id_pc_4"},   id_pc_4,          m.id_pc4);
        check({tag, ".id_valid"},  {31'h0, id_valid}, {31'h0, m.valid});
        check({tag, ".halted"},    {31'h0, halted},   {31'h0, m.halted});
        check({tag, ".fetch_cnt"}, fetch_cnt,        exp_cnt);
    endtask

    // Drive one cycle of stimulus, advance model and DUT, compare after the edge.
    task automatic apply(input stim_t s, input string tag);
        model_t nx;
        rst_n    = s.rst_n;
        en       = s.en;
        stall    = s.stall;
        flush    = s.flush;
        redir_en = s.redir_en;
        redir_pc = s.redir_pc;
        irq_en   = s.irq_en;
        irq_pc   = s.irq_pc;
        halt     = s.halt;
        resume   = s.resume;
        nx = model_next(m, s);
        @(posedge clk);
        #1;
        m = nx;
        compare_all(tag);
    endtask

    vec_t vec[26];

    initial begin
        m = '0;

        // Directed table: stimulus and expected pc / id_pc / id_valid / halted
        vec[0]  = '{run(),                                                 32'h4,         32'h0,         1, 0};
        vec[1]  = '{run(),                                                 32'h8,         32'h4,         1, 0};
        vec[2]  = '{run(),                                                 32'hC,         32'h8,         1, 0};
        vec[3]  = '{st(1,1,1,0,0,32'h0,0,32'h0,0,0),                       32'hC,         32'h8,         1, 0};
        vec[4]  = '{st(1,1,1,0,0,32'h0,0,32'h0,0,0),                       32'hC,         32'h8,         1, 0};
        vec[5]  = '{st(1,1,1,1,0,32'h0,0,32'h0,0,0),                       32'hC,         32'h0,         0, 0};
        vec[6]  = '{st(1,1,1,0,1,32'h103,0,32'h0,0,0),                     32'h100,       32'h0,         0, 0};
        vec[7]  = '{run(),                                                 32'h104,       32'h100,       1, 0};
        vec[8]  = '{st(1,1,0,0,1,32'h200,1,32'h4000,1,0),                  32'h4000,      32'h0,         0, 0};
        vec[9]  = '{st(1,1,0,0,1,32'h20,0,32'h0,0,0),                      32'h20,        32'h0,         0, 0};
        vec[10] = '{st(1,1,0,0,0,32'h0,0,32'h0,1,0),                       32'h20,        32'h0,         0, 1};
        vec[11] = '{run(),                                                 32'h20,        32'h0,         0, 1};
        vec[12] = '{st(1,1,1,1,1,32'h300,0,32'h0,0,0),                     32'h20,        32'h0,         0, 1};
        vec[13] = '{run(),                                                 32'h20,        32'h0,         0, 1};
        vec[14] = '{st(1,1,0,0,0,32'h0,0,32'h0,0,1),                       32'h20,        32'h0,         0, 0};
        vec[15] = '{run(),                                                 32'h24,        32'h20,        1, 0};
        vec[16] = '{st(1,1,0,0,0,32'h0,0,32'h0,1,0),                       32'h24,        32'h0,         0, 1};
        vec[17] = '{st(1,1,0,0,0,32'h0,1,32'h4001,0,0),                    32'h4000,      32'h0,         0, 0};
        vec[18] = '{run(),                                                 32'h4004,      32'h4000,      1, 0};
        vec[19] = '{st(1,1,0,1,0,32'h0,0,32'h0,0,0),                       32'h4008,      32'h0,         0, 0};
        vec[20] = '{run(),                                                 32'h400C,      32'h4008,      1, 0};
        vec[21] = '{st(1,0,0,0,0,32'h0,0,32'h0,0,0),                       32'h400C,      32'h4008,      1, 0};
        vec[22] = '{st(1,0,0,0,0,32'h0,1,32'h8000,0,0),                    32'h400C,      32'h4008,      1, 0};
        vec[23] = '{st(0,0,0,0,0,32'h0,0,32'h0,0,0),                       32'h0,         32'h0,         0, 0};
        vec[24] = '{st(1,1,0,0,1,32'hFFFF_FFFF,0,32'h0,0,0),               32'hFFFF_FFFC, 32'h0,         0, 0};
        vec[25] = '{run(),                                                 32'h0,         32'hFFFF_FFFC, 1, 0};

        // Reset and check the reset state
        apply(st(0,0,0,0,0,32'h0,0,32'h0,0,0), "reset");
        apply(st(0,1,1,1,1,32'h55,1,32'h77,1,1), "reset2");

        for (int i = 0; i < 26; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(vec[i].s, tag);
            check({tag, ".tbl_pc"},     pc,               vec[i].e_pc);
            check({tag, ".tbl_id_pc"},  id_pc,            vec[i].e_id_pc);
            check({tag, ".tbl_valid"},  {31'h0, id_valid}, {31'h0, vec[i].e_valid});
            check({tag, ".tbl_halted"}, {31'h0, halted},   {31'h0, vec[i].e_halted});
        end

        // Wrap at top of address space via an interrupt target
        apply(st(1,1,0,0,0,32'h0,1,32'hFFFF_FFFE,0,0), "wrap_irq");
        apply(run(), "wrap_step");
        check("wrap.pc_zero", pc, 32'h0);

        // Randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            s.rst_n    = ($urandom_range(0, 99) != 0);
            s.en       = ($urandom_range(0, 7) != 0);
            s.stall    = ($urandom_range(0, 3) == 0);
            s.flush    = ($urandom_range(0, 4) == 0);
            s.redir_en = ($urandom_range(0, 5) == 0);
            s.redir_pc = $urandom;
            s.irq_en   = ($urandom_range(0, 9) == 0);
            s.irq_pc   = $urandom;
            s.halt     = ($urandom_range(0, 11) == 0);
            s.resume   = ($urandom_range(0, 2) == 0);
            apply(s, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
